// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word lines and a single blocking fill.
// Define ICACHE_PERF_EN to add the hit_count/miss_count performance counters.
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Exposed for checkers to bind onto.
    state_t state;
    state_t next_state;

    logic [31:2]      fill_addr;
    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             line_hit;
    logic             start_fill;
    logic             fill_done;
    logic             unused_addr_bits;

    assign idx      = imemaddr[IDX_W+1:2];
    assign tag      = imemaddr[31:IDX_W+2];
    assign fill_idx = fill_addr[IDX_W+1:2];
    assign fill_tag = fill_addr[31:IDX_W+2];
    assign line_hit = valid[idx] && (tags[idx] == tag);
    assign unused_addr_bits = ^imemaddr[1:0];

    // Fill handshake: iREN is a pure decode of FILL and stays high until the
    // edge where iwait is low; that edge accepts iload and ends the fill.
    assign iREN     = (state == FILL);
    assign iaddr    = {fill_addr, 2'b00};
    assign imemload = data[idx];

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        start_fill = 1'b0;
        fill_done  = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN) begin
                    if (line_hit) begin
                        ihit = 1'b1;
                    end else begin
                        start_fill = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            fill_addr <= '0;
        end else begin
            state <= next_state;
            if (start_fill) begin
                fill_addr <= imemaddr[31:2];
            end
            if (fill_done) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage carries no reset; a reset edge must still block the write.
    always_ff @(posedge CLK) begin
        if (nRST && fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_fill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios with literal expectations, then random
// traffic checked every cycle against a line-level model of the cache.
module tb_icache;

    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache #(.SETS(SETS), .IDX_W(IDX_W)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .iREN(iREN),
        .iaddr(iaddr),
        .iwait(iwait),
        .iload(iload)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // Clock/reset block
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Model: each line remembers which word address it holds; a pending fill
    // is the single entry of the expected-fill queue.
    logic        m_live = 1'b0;
    logic        m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] exp_q[$];
    int          m_hits;
    int          m_misses;

    function automatic int line_of(input logic [31:0] a);
        return int'(a[IDX_W+1:2]);
    endfunction

    function automatic logic model_hit();
        int i;
        i = line_of(imemaddr);
        return (exp_q.size() == 0) && imemREN && (m_valid[i] === 1'b1) &&
               (m_word[i] == imemaddr[31:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the active edge
    initial begin
        forever begin
            @(posedge CLK);
            if (!nRST) begin
                m_live = 1'b1;
                foreach (m_valid[k]) m_valid[k] = 1'b0;
                exp_q.delete();
                m_hits   = 0;
                m_misses = 0;
            end else if (m_live) begin
                if (exp_q.size() != 0) begin
                    if (!iwait) begin
                        logic [31:0] fa;
                        int i;
                        fa = exp_q.pop_front();
                        i  = line_of(fa);
                        m_valid[i] = 1'b1;
                        m_word[i]  = fa[31:2];
                        m_data[i]  = iload;
                    end
                end else if (imemREN) begin
                    if (model_hit()) begin
                        m_hits++;
                    end else begin
                        exp_q.push_back({imemaddr[31:2], 2'b00});
                        m_misses++;
                    end
                end
            end
        end
    end

    // Compare process on the inactive edge
    initial begin
        forever begin
            @(negedge CLK);
            if (m_live) begin
                logic eh;
                eh = model_hit();
                chk("ihit", {31'd0, ihit}, {31'd0, eh});
                chk("iREN", {31'd0, iREN}, {31'd0, exp_q.size() != 0});
                if (exp_q.size() != 0) chk("iaddr", iaddr, exp_q[0]);
                if (eh) chk("imemload", imemload, m_data[line_of(imemaddr)]);
`ifdef ICACHE_PERF_EN
                chk("hit_count", hit_count, m_hits);
                chk("miss_count", miss_count, m_misses);
`endif
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] word, input int nwait);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        step();
        repeat (nwait) step();
        iwait = 1'b0;
        iload = word;
        step();
        iwait = 1'b1;
    endtask

    logic [31:0] idle_addrs [4];

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        repeat (2) step();
        @(negedge CLK);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_PERF_EN
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
`endif

        // First miss on 0x0 with three wait cycles
        step();
        nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h0;
        @(negedge CLK);
        chk("t1_miss_ihit", {31'd0, ihit}, 32'd0);
        chk("t1_miss_iREN", {31'd0, iREN}, 32'd0);
        step();
        @(negedge CLK);
        chk("t1_fill_iREN", {31'd0, iREN}, 32'd1);
        chk("t1_fill_iaddr", iaddr, 32'h0);
        repeat (3) step();
        iwait = 1'b0; iload = 32'h20010005;
        @(negedge CLK);
        chk("t1_last_iREN", {31'd0, iREN}, 32'd1);
        step();
        iwait = 1'b1;
        @(negedge CLK);
        chk("t1_hit_ihit", {31'd0, ihit}, 32'd1);
        chk("t1_hit_data", imemload, 32'h20010005);
        chk("t1_hit_iREN", {31'd0, iREN}, 32'd0);
        step();
        @(negedge CLK);
        chk("t2_rehit", {31'd0, ihit}, 32'd1);
`ifdef ICACHE_PERF_EN
        chk("t2_hit_count", hit_count, 32'd1);
        chk("t2_miss_count", miss_count, 32'd1);
`endif

        // Conflict eviction on index 1
        step();
        fill(32'h4, 32'h11111111, 0);
        fill(32'h44, 32'hDEADBEEF, 1);
        @(negedge CLK);
        chk("t3_hit44", imemload, 32'hDEADBEEF);
        step();
        imemaddr = 32'h4;
        @(negedge CLK);
        chk("t3_evicted_ihit", {31'd0, ihit}, 32'd0);
        step();
        @(negedge CLK);
        chk("t3_refill_iREN", {31'd0, iREN}, 32'd1);
        chk("t3_refill_iaddr", iaddr, 32'h4);
        iwait = 1'b0; iload = 32'h11111111;
        step();
        iwait = 1'b1;

        // Address change mid-fill
        imemaddr = 32'h8;
        @(negedge CLK);
        chk("t4_miss8", {31'd0, ihit}, 32'd0);
        step();
        imemaddr = 32'h10;
        step();
        @(negedge CLK);
        chk("t4_iaddr_held", iaddr, 32'h8);
        iwait = 1'b0; iload = 32'hCAFE0008;
        step();
        iwait = 1'b1;
        @(negedge CLK);
        chk("t4_miss10", {31'd0, ihit}, 32'd0);
        step();
        iwait = 1'b0; iload = 32'h10101010;
        step();
        iwait = 1'b1; imemaddr = 32'h8;
        @(negedge CLK);
        chk("t4_line2_hit", {31'd0, ihit}, 32'd1);
        chk("t4_line2_data", imemload, 32'hCAFE0008);

        // Reset during a fill
        step();
        imemaddr = 32'h100;
        step();
        @(negedge CLK);
        chk("t5_fill_iREN", {31'd0, iREN}, 32'd1);
        nRST = 1'b0;
        step();
        @(negedge CLK);
        chk("t5_rst_iREN", {31'd0, iREN}, 32'd0);
        step();
        nRST = 1'b1; imemaddr = 32'h0;
        @(negedge CLK);
        chk("t5_lost_line", {31'd0, ihit}, 32'd0);
        step();
        @(negedge CLK);
        chk("t5_refetch_iREN", {31'd0, iREN}, 32'd1);
        iwait = 1'b0; iload = 32'h20010005;
        step();
        iwait = 1'b1;

        // No requests while lines are valid
        idle_addrs[0] = 32'h0; idle_addrs[1] = 32'h8;
        idle_addrs[2] = 32'h10; idle_addrs[3] = 32'h44;
        imemREN = 1'b0;
        for (int n = 0; n < 10; n++) begin
            imemaddr = idle_addrs[$urandom_range(0, 3)];
            @(negedge CLK);
            chk("t6_idle_ihit", {31'd0, ihit}, 32'd0);
            chk("t6_idle_iREN", {31'd0, iREN}, 32'd0);
            step();
        end

        // Random traffic over a small address pool with occasional far tags and resets
        for (int n = 0; n < 3000; n++) begin
            nRST     = ($urandom_range(0, 199) != 0);
            imemREN  = ($urandom_range(0, 9) < 8);
            imemaddr = $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) imemaddr[31:20] = 12'($urandom);
            iwait = ($urandom_range(0, 2) != 0);
            iload = $urandom;
            step();
        end

        nRST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
        step();
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the datapath's fetch requests on the instruction side of `datapath_cache_if` and forwards misses to memory control. It sits between the pipeline's fetch stage and the RAM arbiter. It returns `ihit`/`imemload` to the datapath and issues single-word `iREN` fills to memory on a miss. Blocking: one outstanding miss.

## Interface

Parameters:
- `SETS`, default 16: number of one-word lines; power of two.
- `IDX_W`, default 4: log2(`SETS`).

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `imemREN`  in  1  datapath fetch request.
- `imemaddr`  in  32  fetch byte address; bits [1:0] ignored.
- `ihit`  out  1  `imemload` valid this cycle; datapath advances PC.
- `imemload`  out  32  instruction word.
- `iREN`  out  1  fill read request to memory control.
- `iaddr`  out  32  fill word address, bits [1:0] = 0.
- `iwait`  in  1  memory busy; fill data valid when `iREN` is high and `iwait` is low.
- `iload`  in  32  fill data.
- `hit_count`  out  32  present only with `ICACHE_PERF_EN`.
- `miss_count`  out  32  present only with `ICACHE_PERF_EN`.

## Operation

- Address split:
  - index = `imemaddr[IDX_W+1:2]`
  - tag = `imemaddr[31:IDX_W+2]` (26 bits at default)
- Per line state: valid bit, tag, data word.
- State machine with two states, IDLE and FILL.
- IDLE:
  - `ihit` = `imemREN` & valid[index] & (tag match); `imemload` = data[index].
  - On `imemREN` with a miss: latch `imemaddr` into `fill_addr` and go to FILL.
- FILL:
  - `iREN`=1 and `iaddr`={`fill_addr`[31:2],2'b00}; `ihit`=0.
  - On a cycle with `iwait`=0: write `iload`, tag and valid=1 into line `fill_addr`[index], then return to IDLE.
- The fill always completes once started, even if `imemREN` drops or `imemaddr` changes mid-fill. The line is written from `fill_addr`, never from the live `imemaddr`.
- Conflict on the same index: the new fill overwrites the line. No victim handling, since the cache is read-only.
- `imemREN`=0 in IDLE: `ihit`=0 and no fill starts. `imemload` still shows data[index], but it is don't-care.
- Reset (`nRST`=0 at an edge): state→IDLE, all valid bits→0, `fill_addr`→0.
  - Tag and data arrays are not reset.
  - Reset mid-fill abandons the fill: `iREN` drops in the cycle after the reset edge, and nothing is written.

## Timing

- Values after reset: `ihit`=0 unless a combinational hit occurs (impossible with all lines invalid), `iREN`=0, `iaddr`=0, counters=0.
- Hit latency is 0 cycles: `ihit` is combinational in the same cycle as `imemREN`/`imemaddr`.
- Miss timing:
  - Cycle 0: miss detected and `ihit`=0.
  - Cycles 1..N: `iREN` high.
  - Edge ending cycle N (`iwait`=0): line written.
  - Cycle N+1: `ihit`=1.
  - Total miss penalty = RAM latency + 1 cycle.
- `iREN` is a registered state decode and is glitch-free. It stays high continuously from FILL entry until the completing edge.

## Configuration

- `ICACHE_PERF_EN` defined: adds `hit_count` and `miss_count`, both 32-bit wrapping counters cleared by reset.
  - `hit_count` increments on each cycle with `ihit`=1.
  - `miss_count` increments on each IDLE→FILL transition.
- `ICACHE_PERF_EN` undefined: the counter ports and logic are absent, and the rest of the behaviour is identical.

## Test plan

- Reset, then `imemREN`=1, `imemaddr`=0x00000000:
  - `ihit`=0 and `iREN`=1, `iaddr`=0x0 next cycle.
  - Hold `iwait`=1 for 3 cycles, then 0 with `iload`=0x20010005.
  - `ihit`=1 and `imemload`=0x20010005 one cycle later.
- After the previous fill, request 0x00000000 again:
  - `ihit`=1 in the same cycle, with no `iREN`.
  - With `ICACHE_PERF_EN`: `hit_count` increments and `miss_count`=1.
- Conflict eviction:
  - Fill 0x00000004, then request 0x00000044 (same index 1): miss, fill with 0xDEADBEEF.
  - Re-request 0x00000004: miss again and `iREN`=1.
- Address change mid-fill:
  - Miss on 0x00000008, then switch `imemaddr` to 0x00000010 while `iwait`=1.
  - `iaddr` stays 0x8 and line 2 is written.
  - 0x10 then misses.
- Reset mid-fill:
  - Assert `nRST`=0 during FILL.
  - `iREN`=0 the following cycle.
  - After release, re-requesting a previously filled address misses.
- `imemREN`=0 with valid lines present: `ihit`=0 and `iREN` never asserts for 10 cycles.
